// File: rtl/uart_pkg.sv
// Shared types for the UART receive-side controller.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        ACK,
        WAIT_CLR
    } rx_ctrl_state_t;

    typedef struct packed {
        logic                   parity_err;
        logic [UART_DATA_W-1:0] data;
    } rx_entry_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with a registered head entry.
module uart_sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LVL_W-1:0] level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] ONE_L   = LVL_W'(1);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             push_acc;
    logic             pop_acc;

    // A pop on a full FIFO frees the slot the simultaneous push lands in.
    assign pop_acc  = pop_i && (count_q != '0);
    assign push_acc = push_i && ((count_q != DEPTH_L) || pop_acc);

    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[wr_ptr_q] <= din_i;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_acc && !pop_acc) begin
            count_d = count_q + ONE_L;
        end else if (pop_acc && !push_acc) begin
            count_d = count_q - ONE_L;
        end
        // The head register holds its value once the FIFO drains.
        if (push_acc && ((count_q == '0) || (pop_acc && (count_q == ONE_L)))) begin
            head_d = din_i;
        end else if (pop_acc && (count_q > ONE_L)) begin
            head_d = mem[rd_ptr_q + PTR_W'(1)];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign dout_o  = head_q;
    assign level_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == DEPTH_L);

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive controller: frame capture FSM, RX FIFO, overrun, RTS hysteresis, interrupt.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int RTS_HI     = 12,
    parameter int RTS_LO     = 8,
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   rx_done,
    input  logic [UART_DATA_W-1:0] rx_data,
    input  logic                   parity_error,
    output logic                   host_read_data,
    output logic                   rts_n,
    input  logic                   pop,
    output logic [UART_DATA_W-1:0] rd_data,
    output logic                   rd_parity_err,
    output logic                   fifo_empty,
    output logic                   fifo_full,
    output logic [LVL_W-1:0]       fifo_level,
    output logic                   overrun,
    input  logic                   clr_overrun,
    input  logic                   int_en,
    output logic                   rx_int
);

    localparam logic [LVL_W-1:0] RTS_HI_L = LVL_W'(RTS_HI);
    localparam logic [LVL_W-1:0] RTS_LO_L = LVL_W'(RTS_LO);

    rx_ctrl_state_t state_q, state_d;
    logic           push_req;
    logic           drop;
    logic           overrun_q, overrun_d;
    logic           rts_q, rts_d;
    logic           rx_int_q, rx_int_d;
    rx_entry_t      push_entry;
    rx_entry_t      head_entry;

    assign push_entry = '{parity_err: parity_error, data: rx_data};

    uart_sync_fifo #(
        .WIDTH ($bits(rx_entry_t)),
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push_req),
        .pop_i   (pop),
        .din_i   (push_entry),
        .dout_o  (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // WAIT_CLR keeps a long rx_done from producing a second push.
    always_comb begin
        state_d        = state_q;
        push_req       = 1'b0;
        drop           = 1'b0;
        host_read_data = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_done) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (!fifo_full || pop) begin
                    push_req = 1'b1;
                end else begin
                    drop = 1'b1;
                end
                state_d = ACK;
            end
            ACK: begin
                host_read_data = 1'b1;
                state_d        = WAIT_CLR;
            end
            WAIT_CLR: begin
                if (!rx_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        overrun_d = overrun_q;
        if (drop) begin
            overrun_d = 1'b1;
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
        end

        rts_d = rts_q;
        if (fifo_level >= RTS_HI_L) begin
            rts_d = 1'b1;
        end else if (fifo_level <= RTS_LO_L) begin
            rts_d = 1'b0;
        end

        rx_int_d = int_en && ((fifo_level >= RTS_LO_L) || overrun_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun_q <= 1'b0;
            rts_q     <= 1'b0;
            rx_int_q  <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
            rts_q     <= rts_d;
            rx_int_q  <= rx_int_d;
        end
    end

    assign overrun       = overrun_q;
    assign rts_n         = rts_q;
    assign rx_int        = rx_int_q;
    assign rd_data       = head_entry.data;
    assign rd_parity_err = head_entry.parity_err;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl against a queue-based reference model.
module tb_uart_rx_ctrl;

    localparam int DEPTH = 16;
    localparam int HI    = 12;
    localparam int LO    = 8;
    localparam int LW    = 5;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          rx_done = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          parity_error = 1'b0;
    logic          pop = 1'b0;
    logic          clr_overrun = 1'b0;
    logic          int_en = 1'b0;
    logic          host_read_data;
    logic          rts_n;
    logic [7:0]    rd_data;
    logic          rd_parity_err;
    logic          fifo_empty;
    logic          fifo_full;
    logic [LW-1:0] fifo_level;
    logic          overrun;
    logic          rx_int;

    uart_rx_ctrl #(.FIFO_DEPTH(DEPTH), .RTS_HI(HI), .RTS_LO(LO), .LVL_W(LW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .rx_done        (rx_done),
        .rx_data        (rx_data),
        .parity_error   (parity_error),
        .host_read_data (host_read_data),
        .rts_n          (rts_n),
        .pop            (pop),
        .rd_data        (rd_data),
        .rd_parity_err  (rd_parity_err),
        .fifo_empty     (fifo_empty),
        .fifo_full      (fifo_full),
        .fifo_level     (fifo_level),
        .overrun        (overrun),
        .clr_overrun    (clr_overrun),
        .int_en         (int_en),
        .rx_int         (rx_int)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: stored entries as {parity, data}, plus sticky flags.
    logic [8:0] mq[$];
    int         m_ovr = 0;
    int         m_rts = 0;
    int         m_int_en = 0;

    typedef struct {
        logic [7:0] d;
        logic       p;
        int         hold;
        int         exp_level;
        logic [7:0] exp_data;
        logic       exp_par;
    } vec_t;

    vec_t tv[4];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_rts();
        if (mq.size() >= HI) m_rts = 1;
        else if (mq.size() <= LO) m_rts = 0;
    endtask

    task automatic check_state(input string tag);
        int exp_int;
        exp_int = (m_int_en != 0 && (mq.size() >= LO || m_ovr != 0)) ? 1 : 0;
        check({tag, " level"}, int'(fifo_level), mq.size());
        check({tag, " empty"}, int'(fifo_empty), (mq.size() == 0) ? 1 : 0);
        check({tag, " full"}, int'(fifo_full), (mq.size() == DEPTH) ? 1 : 0);
        check({tag, " overrun"}, int'(overrun), m_ovr);
        check({tag, " rts_n"}, int'(rts_n), m_rts);
        check({tag, " rx_int"}, int'(rx_int), exp_int);
        if (mq.size() > 0) begin
            check({tag, " rd_data"}, int'(rd_data), int'(mq[0][7:0]));
            check({tag, " rd_parity_err"}, int'(rd_parity_err), int'(mq[0][8]));
        end
        $display("[%s] level=%0d rd_data=%02h ovr=%0d rts_n=%0d rx_int=%0d",
                 tag, fifo_level, rd_data, overrun, rts_n, rx_int);
    endtask

    // Frame with rx_done held for hold (>=3) cycles; optional pop in the CAPTURE cycle.
    task automatic send_frame(input logic [7:0] d, input logic p, input int hold, input bit pop_cap);
        int pulses;
        int first;
        bit was_full;
        pulses = 0;
        first  = -1;
        rx_data = d;
        parity_error = p;
        rx_done = 1'b1;
        for (int i = 1; i <= hold + 2; i++) begin
            if (i == hold + 1) rx_done = 1'b0;
            tick();
            if (host_read_data) begin
                pulses++;
                if (first < 0) first = i;
            end
            if (pop_cap && i == 1) pop = 1'b1;
            if (i == 2) pop = 1'b0;
        end
        check("ack pulses", pulses, 1);
        check("ack latency", first, 2);
        was_full = (mq.size() == DEPTH);
        if (pop_cap && mq.size() > 0) void'(mq.pop_front());
        if (!was_full || pop_cap) mq.push_back({p, d});
        else m_ovr = 1;
        model_rts();
    endtask

    task automatic pop_one();
        if (mq.size() > 0) begin
            check("pop head data", int'(rd_data), int'(mq[0][7:0]));
        end
        pop = 1'b1;
        tick();
        pop = 1'b0;
        tick();
        if (mq.size() > 0) void'(mq.pop_front());
        model_rts();
    endtask

    task automatic clear_ovr();
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        tick();
        m_ovr = 0;
    endtask

    task automatic flush();
        while (mq.size() > 0) pop_one();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int pulses;

        tv[0] = '{d: 8'hA5, p: 1'b0, hold: 20, exp_level: 1, exp_data: 8'hA5, exp_par: 1'b0};
        tv[1] = '{d: 8'h5A, p: 1'b1, hold: 3,  exp_level: 1, exp_data: 8'h5A, exp_par: 1'b1};
        tv[2] = '{d: 8'hFF, p: 1'b0, hold: 7,  exp_level: 1, exp_data: 8'hFF, exp_par: 1'b0};
        tv[3] = '{d: 8'h00, p: 1'b1, hold: 4,  exp_level: 1, exp_data: 8'h00, exp_par: 1'b1};

        // Reset values
        repeat (2) tick();
        check("reset level", int'(fifo_level), 0);
        check("reset empty", int'(fifo_empty), 1);
        check("reset full", int'(fifo_full), 0);
        check("reset host_read_data", int'(host_read_data), 0);
        check("reset rts_n", int'(rts_n), 0);
        check("reset overrun", int'(overrun), 0);
        check("reset rx_int", int'(rx_int), 0);
        check("reset rd_data", int'(rd_data), 0);
        check("reset rd_parity_err", int'(rd_parity_err), 0);
        reset_n = 1'b1;
        tick();

        // Single frames from the vector table
        for (int i = 0; i < 4; i++) begin
            send_frame(tv[i].d, tv[i].p, tv[i].hold, 1'b0);
            check("vec level", int'(fifo_level), tv[i].exp_level);
            check("vec rd_data", int'(rd_data), int'(tv[i].exp_data));
            check("vec rd_parity_err", int'(rd_parity_err), int'(tv[i].exp_par));
            pop_one();
            check("vec empty after pop", int'(fifo_empty), 1);
        end

        // Pop on empty is ignored
        pop_one();
        check_state("pop on empty");

        // Fill and overrun
        int_en = 1'b1;
        m_int_en = 1;
        tick();
        for (int i = 0; i < 17; i++) begin
            send_frame(8'(i), 1'b0, 3, 1'b0);
            if (i == 15) check("fill full", int'(fifo_full), 1);
        end
        check_state("after 17 frames");
        check("fill overrun", int'(overrun), 1);
        for (int i = 0; i < 16; i++) begin
            check("fill order", int'(rd_data), i);
            pop_one();
        end
        check_state("drained with overrun");
        clear_ovr();
        check("overrun cleared", int'(overrun), 0);
        check_state("after clr_overrun");

        // RTS hysteresis
        for (int i = 0; i < 12; i++) send_frame(8'(8'h20 + i), 1'b0, 3, 1'b0);
        check("rts high at 12", int'(rts_n), 1);
        for (int i = 0; i < 3; i++) pop_one();
        check("rts level 9", int'(fifo_level), 9);
        check("rts holds at 9", int'(rts_n), 1);
        pop = 1'b1;
        tick();
        pop = 1'b0;
        void'(mq.pop_front());
        check("rts level 8", int'(fifo_level), 8);
        check("rts still high same cycle", int'(rts_n), 1);
        tick();
        check("rts low after 8", int'(rts_n), 0);
        m_rts = 0;
        check_state("rts sequence");
        flush();

        // Push and pop together on a full FIFO
        for (int i = 0; i < 16; i++) send_frame(8'(8'h40 + i), 1'b0, 3, 1'b0);
        send_frame(8'h99, 1'b0, 4, 1'b1);
        check("full push+pop level", int'(fifo_level), 16);
        check("full push+pop overrun", int'(overrun), 0);
        check_state("full push+pop");
        for (int i = 0; i < 15; i++) pop_one();
        check("last entry is new frame", int'(rd_data), 8'h99);
        pop_one();

        // Parity propagation
        send_frame(8'h3C, 1'b1, 3, 1'b0);
        check("parity head set", int'(rd_parity_err), 1);
        send_frame(8'h3D, 1'b0, 3, 1'b0);
        pop_one();
        check("parity head clear", int'(rd_parity_err), 0);
        check("parity head data", int'(rd_data), 8'h3D);
        pop_one();

        // Randomized operations against the model
        for (int n = 0; n < 250; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r <= 4) begin
                send_frame(8'($urandom), 1'($urandom), int'($urandom_range(3, 6)),
                           ($urandom_range(0, 3) == 0));
            end else if (r <= 7) begin
                pop_one();
            end else if (r == 8) begin
                clear_ovr();
            end else begin
                int_en = 1'($urandom);
                m_int_en = int'(int_en);
                tick();
                tick();
            end
            check_state("random");
        end

        // Reset mid-operation during ACK
        flush();
        clear_ovr();
        for (int i = 0; i < 5; i++) send_frame(8'(8'h60 + i), 1'b0, 3, 1'b0);
        rx_data = 8'h77;
        parity_error = 1'b0;
        rx_done = 1'b1;
        tick();
        tick();
        check("in ACK before reset", int'(host_read_data), 1);
        reset_n = 1'b0;
        #1;
        check("mid reset host_read_data", int'(host_read_data), 0);
        check("mid reset level", int'(fifo_level), 0);
        check("mid reset empty", int'(fifo_empty), 1);
        check("mid reset full", int'(fifo_full), 0);
        check("mid reset rts_n", int'(rts_n), 0);
        check("mid reset overrun", int'(overrun), 0);
        check("mid reset rx_int", int'(rx_int), 0);
        check("mid reset rd_data", int'(rd_data), 0);
        mq.delete();
        m_ovr = 0;
        m_rts = 0;
        tick();
        reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (host_read_data) pulses++;
        end
        rx_done = 1'b0;
        tick();
        tick();
        check("recapture after reset", pulses, 1);
        mq.push_back({1'b0, 8'h77});
        check_state("after reset recapture");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
